eco32f_writeback: RTL and testbench

Memory-to-writeback stage of the eco32f pipeline and the write-side counterpart of the register file. It accepts the memory-stage result, and for loads it runs the data-bus read, aligns and extends the returned data, and times out the access if needed. It registers the final result and drives the register-file write port (`wb_rf_r_addr`/`wb_rf_r_we`/`wb_rf_r`), which also feeds the register file's mem-stage bypass.

---
 rtl/eco32f_writeback.sv | 173 +++++++++++++++++
 tb/tb_eco32f_writeback.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_writeback.sv
// Memory-to-writeback stage: ALU results and aligned/extended load data into the register-file write port.
// Latency: ALU ops 1 cycle; loads write 1 cycle after dbus_ack, or give up after BUS_TIMEOUT cycles.
// Backpressure: mem_stall holds upstream from load accept until ack/err/timeout; held through DISCARD.
module eco32f_writeback #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_flush,
    input  logic [4:0]  mem_rf_r_addr,
    input  logic        mem_rf_r_we,
    input  logic [31:0] mem_alu_result,
    input  logic        mem_load,
    input  logic [1:0]  mem_lsu_size,
    input  logic        mem_lsu_signed,
    output logic        dbus_req,
    output logic [31:0] dbus_adr,
    input  logic [31:0] dbus_dat_i,
    input  logic        dbus_ack,
    input  logic        dbus_err,
    output logic        mem_stall,
    output logic [4:0]  wb_rf_r_addr,
    output logic        wb_rf_r_we,
    output logic [31:0] wb_rf_r,
    output logic        wb_bus_err,
    output logic        wb_align_err
);

    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Load context captured at accept, used when the bus answers.
    logic [CW-1:0] cnt;
    logic [1:0]    ld_off;
    logic [1:0]    ld_size;
    logic          ld_signed;
    logic [4:0]    ld_dest;
    logic          ld_we;

    logic        acc;
    logic        misaligned;
    logic        timeout;
    logic        done;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;

    // Accept, alignment, completion and stall decode.
    always_comb begin
        acc        = mem_valid & ~mem_flush & (state == S_IDLE);
        // Size 11 is treated as a word, so size[1] covers both word encodings.
        misaligned = ((mem_lsu_size == 2'b01) & mem_alu_result[0])
                   | (mem_lsu_size[1] & (mem_alu_result[1:0] != 2'b00));
        timeout    = (state != S_IDLE) & (cnt == TO_LAST);
        done       = dbus_ack | dbus_err | timeout;
        mem_stall  = (acc & mem_load & ~misaligned)
                   | ((state == S_WAIT) & ~done)
                   | (state == S_DISCARD);
    end

    // Big-endian lane select and sign/zero extension of returned read data.
    always_comb begin
        case (ld_off)
            2'd0:    lane_b = dbus_dat_i[31:24];
            2'd1:    lane_b = dbus_dat_i[23:16];
            2'd2:    lane_b = dbus_dat_i[15:8];
            default: lane_b = dbus_dat_i[7:0];
        endcase
        lane_h = ld_off[1] ? dbus_dat_i[15:0] : dbus_dat_i[31:16];
        case (ld_size)
            2'b00:   ld_data = {{24{ld_signed & lane_b[7]}}, lane_b};
            2'b01:   ld_data = {{16{ld_signed & lane_h[15]}}, lane_h};
            default: ld_data = dbus_dat_i;
        endcase
    end

    // Next state: completion takes priority over a flush arriving in the same WAIT cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (acc & mem_load & ~misaligned) state_nxt = S_WAIT;
            S_WAIT: begin
                if (done)           state_nxt = S_IDLE;
                else if (mem_flush) state_nxt = S_DISCARD;
            end
            S_DISCARD: if (done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Bus request, load context, timeout counter and register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_req     <= 1'b0;
            dbus_adr     <= 32'd0;
            cnt          <= '0;
            ld_off       <= 2'd0;
            ld_size      <= 2'd0;
            ld_signed    <= 1'b0;
            ld_dest      <= 5'd0;
            ld_we        <= 1'b0;
            wb_rf_r_addr <= 5'd0;
            wb_rf_r_we   <= 1'b0;
            wb_rf_r      <= 32'd0;
            wb_bus_err   <= 1'b0;
            wb_align_err <= 1'b0;
        end else begin
            wb_bus_err   <= 1'b0;
            wb_align_err <= 1'b0;
            wb_rf_r_we   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (!mem_load) begin
                            wb_rf_r      <= mem_alu_result;
                            wb_rf_r_addr <= mem_rf_r_addr;
                            wb_rf_r_we   <= mem_rf_r_we & (mem_rf_r_addr != 5'd0);
                        end else if (misaligned) begin
                            wb_align_err <= 1'b1;
                        end else begin
                            dbus_req  <= 1'b1;
                            dbus_adr  <= {mem_alu_result[31:2], 2'b00};
                            ld_off    <= mem_alu_result[1:0];
                            ld_size   <= mem_lsu_size;
                            ld_signed <= mem_lsu_signed;
                            ld_dest   <= mem_rf_r_addr;
                            ld_we     <= mem_rf_r_we;
                            cnt       <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        dbus_req <= 1'b0;
                        // A flush landing on the completion cycle kills the result silently.
                        if (!mem_flush) begin
                            if (dbus_err | ~dbus_ack) begin
                                wb_bus_err <= 1'b1;
                            end else begin
                                wb_rf_r      <= ld_data;
                                wb_rf_r_addr <= ld_dest;
                                wb_rf_r_we   <= ld_we & (ld_dest != 5'd0);
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DISCARD: begin
                    if (done) dbus_req <= 1'b0;
                    else      cnt      <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eco32f_writeback.sv
module tb_eco32f_writeback;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        mem_valid, mem_flush;
    logic [4:0]  mem_rf_r_addr;
    logic        mem_rf_r_we;
    logic [31:0] mem_alu_result;
    logic        mem_load;
    logic [1:0]  mem_lsu_size;
    logic        mem_lsu_signed;
    logic        dbus_req;
    logic [31:0] dbus_adr;
    logic [31:0] dbus_dat_i;
    logic        dbus_ack, dbus_err;
    logic        mem_stall;
    logic [4:0]  wb_rf_r_addr;
    logic        wb_rf_r_we;
    logic [31:0] wb_rf_r;
    logic        wb_bus_err, wb_align_err;

    eco32f_writeback #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_flush(mem_flush),
        .mem_rf_r_addr(mem_rf_r_addr), .mem_rf_r_we(mem_rf_r_we),
        .mem_alu_result(mem_alu_result), .mem_load(mem_load),
        .mem_lsu_size(mem_lsu_size), .mem_lsu_signed(mem_lsu_signed),
        .dbus_req(dbus_req), .dbus_adr(dbus_adr), .dbus_dat_i(dbus_dat_i),
        .dbus_ack(dbus_ack), .dbus_err(dbus_err), .mem_stall(mem_stall),
        .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r(wb_rf_r),
        .wb_bus_err(wb_bus_err), .wb_align_err(wb_align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit started = 0;

    // Reference model: one outstanding load at most, plus the visible outputs.
    bit          m_busy, m_keep;
    int          m_cnt;
    logic [1:0]  m_off, m_size;
    logic        m_sgn, m_lwe;
    logic [4:0]  m_dest;
    logic        m_req, m_rf_we, m_berr, m_aerr;
    logic [31:0] m_adr, m_rf;
    logic [4:0]  m_rf_addr;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_misaligned(logic [1:0] size, logic [31:0] a);
        if (size == 2'b01) return (a % 2) != 0;
        if (size[1])       return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_align(logic [31:0] d, logic [1:0] off, logic [1:0] size, logic sgn);
        logic [31:0] v;
        if (size[1]) return d;
        if (size == 2'b00) begin
            v = (d >> (8 * (3 - int'(off)))) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFFFF00;
        end else begin
            v = (d >> (off[1] ? 0 : 16)) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic bit m_stall();
        bit acc;
        acc = mem_valid && !mem_flush && !m_busy;
        return (acc && mem_load && !m_misaligned(mem_lsu_size, mem_alu_result))
            || (m_busy && m_keep && !dbus_ack && !dbus_err && m_cnt != TO - 1)
            || (m_busy && !m_keep);
    endfunction

    task automatic model_step();
        bit acc, to;
        if (rst) begin
            m_busy = 0; m_keep = 0; m_cnt = 0; m_req = 0; m_adr = 0;
            m_rf = 0; m_rf_addr = 0; m_rf_we = 0; m_berr = 0; m_aerr = 0;
        end else begin
            m_berr = 0; m_aerr = 0; m_rf_we = 0;
            acc = mem_valid && !mem_flush && !m_busy;
            if (!m_busy) begin
                if (acc) begin
                    if (!mem_load) begin
                        m_rf = mem_alu_result;
                        m_rf_addr = mem_rf_r_addr;
                        m_rf_we = mem_rf_r_we && (mem_rf_r_addr != 0);
                    end else if (m_misaligned(mem_lsu_size, mem_alu_result)) begin
                        m_aerr = 1;
                    end else begin
                        m_busy = 1; m_keep = 1; m_cnt = 0; m_req = 1;
                        m_adr = mem_alu_result & 32'hFFFFFFFC;
                        m_off = mem_alu_result[1:0]; m_size = mem_lsu_size;
                        m_sgn = mem_lsu_signed; m_dest = mem_rf_r_addr; m_lwe = mem_rf_r_we;
                    end
                end
            end else begin
                to = (m_cnt == TO - 1);
                if (dbus_ack || dbus_err || to) begin
                    m_busy = 0; m_req = 0;
                    if (m_keep && !mem_flush) begin
                        if (dbus_ack && !dbus_err) begin
                            m_rf = m_align(dbus_dat_i, m_off, m_size, m_sgn);
                            m_rf_addr = m_dest;
                            m_rf_we = m_lwe && (m_dest != 0);
                        end else begin
                            m_berr = 1;
                        end
                    end
                end else begin
                    m_cnt++;
                    if (mem_flush) m_keep = 0;
                end
            end
        end
    endtask

    // Compare every output against the model each cycle, away from the clock edge.
    always @(negedge clk) begin
        if (started) begin
            chk("dbus_req", 32'(dbus_req), 32'(m_req));
            chk("dbus_adr", dbus_adr, m_adr);
            chk("mem_stall", 32'(mem_stall), 32'(m_stall()));
            chk("wb_rf_r_addr", 32'(wb_rf_r_addr), 32'(m_rf_addr));
            chk("wb_rf_r_we", 32'(wb_rf_r_we), 32'(m_rf_we));
            chk("wb_rf_r", wb_rf_r, m_rf);
            chk("wb_bus_err", 32'(wb_bus_err), 32'(m_berr));
            chk("wb_align_err", 32'(wb_align_err), 32'(m_aerr));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet();
        mem_valid = 0; mem_flush = 0; mem_load = 0; dbus_ack = 0; dbus_err = 0;
    endtask

    task automatic alu_op(logic [31:0] res, logic [4:0] dst);
        mem_valid = 1; mem_flush = 0; mem_load = 0; mem_alu_result = res;
        mem_rf_r_addr = dst; mem_rf_r_we = 1; mem_lsu_size = 2'b10; mem_lsu_signed = 0;
    endtask

    task automatic load_op(logic [31:0] a, logic [1:0] sz, logic sgn, logic [4:0] dst);
        mem_valid = 1; mem_flush = 0; mem_load = 1; mem_alu_result = a;
        mem_rf_r_addr = dst; mem_rf_r_we = 1; mem_lsu_size = sz; mem_lsu_signed = sgn;
    endtask

    initial begin
        int stall_n, req_n;
        rst = 1; quiet(); mem_rf_r_addr = 0; mem_rf_r_we = 0; mem_alu_result = 0;
        mem_lsu_size = 0; mem_lsu_signed = 0; dbus_dat_i = 0;
        tick();
        started = 1;
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_rf", wb_rf_r, 32'd0);
        tick();
        rst = 0;

        // ALU result: 1-cycle write, no stall; $0 never written.
        alu_op(32'h12345678, 5'd5); #1;
        chk("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        chk("alu_rf", wb_rf_r, 32'h12345678);
        chk("alu_addr", 32'(wb_rf_r_addr), 32'd5);
        chk("alu_we", 32'(wb_rf_r_we), 32'd1);
        alu_op(32'h12345678, 5'd0);
        tick();
        chk("alu_r0_we", 32'(wb_rf_r_we), 32'd0);

        // Signed byte load at 0x1001, ack after three WAIT cycles.
        load_op(32'h1001, 2'b00, 1, 5'd7);
        stall_n = 0;
        #1; if (mem_stall) stall_n++;
        tick();
        chk("lb_adr", dbus_adr, 32'h1000);
        chk("lb_req", 32'(dbus_req), 32'd1);
        quiet();
        for (int i = 0; i < 3; i++) begin
            #1; if (mem_stall) stall_n++;
            tick();
        end
        dbus_ack = 1; dbus_dat_i = 32'h1180FF22; #1;
        chk("lb_stall_ack", 32'(mem_stall), 32'd0);
        chk("lb_stall_cycles", 32'(stall_n), 32'd4);
        tick();
        chk("lb_rf", wb_rf_r, 32'hFFFFFF80);
        chk("lb_we", 32'(wb_rf_r_we), 32'd1);
        chk("lb_addr", 32'(wb_rf_r_addr), 32'd7);
        chk("lb_req_drop", 32'(dbus_req), 32'd0);
        quiet();
        load_op(32'h1001, 2'b00, 0, 5'd7);
        tick();
        quiet(); dbus_ack = 1;
        tick();
        chk("lbu_rf", wb_rf_r, 32'h00000080);

        // Signed half load, then misaligned word.
        load_op(32'h2002, 2'b01, 1, 5'd9);
        tick();
        quiet(); dbus_ack = 1; dbus_dat_i = 32'hAAAA8001;
        tick();
        chk("lh_rf", wb_rf_r, 32'hFFFF8001);
        load_op(32'h3001, 2'b10, 0, 5'd9);
        tick();
        chk("lw_align_err", 32'(wb_align_err), 32'd1);
        chk("lw_align_req", 32'(dbus_req), 32'd0);
        chk("lw_align_we", 32'(wb_rf_r_we), 32'd0);
        quiet();
        tick();
        chk("lw_align_pulse", 32'(wb_align_err), 32'd0);

        // Timeout with no ack.
        load_op(32'h4000, 2'b10, 0, 5'd3);
        tick();
        quiet();
        req_n = 0;
        while (dbus_req && req_n < 20) begin
            tick();
            req_n++;
        end
        chk("to_cycles", 32'(req_n), 32'(TO));
        chk("to_berr", 32'(wb_bus_err), 32'd1);
        chk("to_we", 32'(wb_rf_r_we), 32'd0);
        tick();
        chk("to_pulse", 32'(wb_bus_err), 32'd0);

        // Error and ack together: error wins.
        load_op(32'h4004, 2'b10, 0, 5'd3);
        tick();
        quiet(); dbus_ack = 1; dbus_err = 1;
        tick();
        chk("errack_berr", 32'(wb_bus_err), 32'd1);
        chk("errack_we", 32'(wb_rf_r_we), 32'd0);
        quiet();

        // Flush in 2nd WAIT cycle, ack in 4th.
        load_op(32'h5000, 2'b10, 0, 5'd4);
        tick();
        quiet();
        tick();
        mem_flush = 1;
        tick();
        mem_flush = 0;
        tick();
        dbus_ack = 1; #1;
        chk("disc_req_held", 32'(dbus_req), 32'd1);
        tick();
        chk("disc_req", 32'(dbus_req), 32'd0);
        chk("disc_we", 32'(wb_rf_r_we), 32'd0);
        chk("disc_berr", 32'(wb_bus_err), 32'd0);
        alu_op(32'hCAFEF00D, 5'd12);
        tick();
        chk("disc_next_we", 32'(wb_rf_r_we), 32'd1);
        chk("disc_next_rf", wb_rf_r, 32'hCAFEF00D);

        // Reset mid-load.
        load_op(32'h6000, 2'b10, 0, 5'd6);
        tick();
        quiet();
        tick();
        rst = 1;
        tick();
        rst = 0; #1;
        chk("rstw_req", 32'(dbus_req), 32'd0);
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        chk("rstw_rf", wb_rf_r, 32'd0);
        chk("rstw_addr", 32'(wb_rf_r_addr), 32'd0);
        dbus_ack = 1; dbus_dat_i = 32'h55555555;
        tick();
        chk("rstw_late_ack", 32'(wb_rf_r_we), 32'd0);
        quiet();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            mem_valid      = ($urandom_range(0, 3) != 0);
            mem_load       = $urandom_range(0, 1);
            mem_lsu_size   = 2'($urandom_range(0, 3));
            mem_lsu_signed = $urandom_range(0, 1);
            mem_rf_r_addr  = 5'($urandom_range(0, 31));
            mem_rf_r_we    = ($urandom_range(0, 7) != 0);
            mem_alu_result = $urandom;
            dbus_dat_i     = $urandom;
            if (m_req) begin
                dbus_ack = ($urandom_range(0, 3) == 0);
                dbus_err = ($urandom_range(0, 15) == 0);
            end else begin
                dbus_ack = ($urandom_range(0, 15) == 0);
                dbus_err = 0;
            end
            mem_flush = ($urandom_range(0, 7) == 0);
            if (m_busy && m_keep && (dbus_ack || dbus_err || m_cnt == TO - 1)) mem_flush = 0;
            tick();
        end
        rst = 0; quiet();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
